// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types for the scan chain controller: FSM state encoding and counter sizing.
package scan_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        DONE
    } state_e;

    // Counter must reach CHAIN_LEN-1; sized like the design's CNT_W parameter.
    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host-side request/response bus of the scan chain controller.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_capture_i;
    logic [CHAIN_LEN-1:0] req_data_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [CHAIN_LEN-1:0] rsp_data_o;

    modport master (
        output req_valid_i, req_capture_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_capture_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Initiator end of a discrete scan chain: shifts a host pattern in while shifting the
// previous chain contents out, with an optional functional capture cycle first.
module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    scan_chain_ctrl_if.slave  bus,
    output logic              scan_en_o,
    output logic              scan_d_o,
    input  logic              scan_q_i,
    output logic              busy_o
);

    state_e               state_q;
    logic [CHAIN_LEN-1:0] sr_q;
    logic [CHAIN_LEN-1:0] sr_d;
    logic [CHAIN_LEN-1:0] rsp_data_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic                 scan_en_q;
    logic                 busy_q;

    // Written as a function so a one-cell chain needs no zero-width slice.
    function automatic logic [CHAIN_LEN-1:0] shift_in(input logic [CHAIN_LEN-1:0] v,
                                                      input logic b);
        logic [CHAIN_LEN-1:0] r;
        r = v >> 1;
        r[CHAIN_LEN-1] = b;
        return r;
    endfunction

    assign sr_d = shift_in(sr_q, scan_q_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            scan_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        sr_q        <= bus.req_data_i;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.req_capture_i) begin
                            state_q <= CAPTURE;
                        end else begin
                            state_q   <= SHIFT;
                            scan_en_q <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    state_q   <= SHIFT;
                    scan_en_q <= 1'b1;
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Last shift edge: drop scan_en together with the final bit.
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_q     <= DONE;
                        scan_en_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= sr_d;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    scan_en_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign scan_en_o       = scan_en_q;
    assign scan_d_o        = sr_q[0];
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 8-cell and 1-cell instances, each driving a behavioural chain.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.CHAIN_LEN(8)) b8 ();
    scan_chain_ctrl_if #(.CHAIN_LEN(1)) b1 ();

    logic se8, sd8, q8, busy8;
    logic se1, sd1, q1, busy1;

    scan_chain_ctrl #(.CHAIN_LEN(8)) u8 (
        .clk_i(clk), .rst_i(rst), .bus(b8),
        .scan_en_o(se8), .scan_d_o(sd8), .scan_q_i(q8), .busy_o(busy8)
    );

    scan_chain_ctrl #(.CHAIN_LEN(1)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(b1),
        .scan_en_o(se1), .scan_d_o(sd1), .scan_q_i(q1), .busy_o(busy1)
    );

    // Chain of scan flops: scan_en selects scan path, else functional enable loads fd.
    logic [7:0] c8, fd8;
    logic       fen8;
    logic       c1, fd1, fen1;
    always @(posedge clk) begin
        if (se8)       c8 <= {c8[6:0], sd8};
        else if (fen8) c8 <= fd8;
        if (se1)       c1 <= sd1;
        else if (fen1) c1 <= fd1;
    end
    assign q8 = c8[7];
    assign q1 = c1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic preload8(input logic [7:0] v);
        fd8 = v; fen8 = 1'b1;
        @(negedge clk);
        fen8 = 1'b0;
    endtask

    // One full operation on the 8-cell instance; called just after a negedge with DUT idle.
    task automatic op8(input logic [7:0] data, input bit cap, input logic [7:0] fdv,
                       input int stall, input bit hold_next, input logic [7:0] next_data,
                       output logic [7:0] got);
        logic [7:0] pre;
        logic [7:0] rstable;
        int k, sec;
        bit done;
        pre = cap ? fdv : c8;
        fd8 = fdv; fen8 = cap;
        b8.req_valid_i = 1'b1; b8.req_data_i = data; b8.req_capture_i = cap;
        b8.rsp_ready_i = 1'b0;
        chk("req_ready_idle", b8.req_ready_o, 1);
        k = 0; sec = 0; done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            b8.req_valid_i = 1'b0;
            if (k == 2) fen8 = 1'b0;
            if (cap && k == 1) chk("capture_scan_en_low", se8, 0);
            if (se8) sec++;
            if (b8.rsp_valid_o) done = 1;
        end
        chk("latency", k, N + 1 + int'(cap));
        chk("scan_en_cycles", sec, N);
        chk("rsp_data", b8.rsp_data_o, rev8(pre));
        chk("chain_loaded", c8, rev8(data));
        rstable = b8.rsp_data_o;
        if (hold_next) begin
            b8.req_valid_i = 1'b1; b8.req_data_i = next_data; b8.req_capture_i = 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_rsp_valid", b8.rsp_valid_o, 1);
            chk("stall_rsp_data", b8.rsp_data_o, rstable);
            chk("stall_req_ready", b8.req_ready_o, 0);
        end
        b8.rsp_ready_i = 1'b1;
        @(negedge clk);
        b8.rsp_ready_i = 1'b0;
        chk("post_rsp_valid", b8.rsp_valid_o, 0);
        chk("post_req_ready", b8.req_ready_o, 1);
        chk("post_busy", busy8, 0);
        got = rstable;
    endtask

    logic [7:0] got;
    int k1, sec1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        b8.req_valid_i = 0; b8.req_capture_i = 0; b8.req_data_i = '0; b8.rsp_ready_i = 0;
        b1.req_valid_i = 0; b1.req_capture_i = 0; b1.req_data_i = '0; b1.rsp_ready_i = 0;
        fd8 = '0; fen8 = 0; fd1 = 0; fen1 = 0;
        b8.req_valid_i = 1'b1; // must not be accepted while reset is high
        repeat (3) @(negedge clk);
        chk("rst_req_ready", b8.req_ready_o, 1);
        chk("rst_rsp_valid", b8.rsp_valid_o, 0);
        chk("rst_scan_en", se8, 0);
        chk("rst_scan_d", sd8, 0);
        chk("rst_rsp_data", b8.rsp_data_o, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_busy_len1", busy1, 0);
        b8.req_valid_i = 1'b0;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready", b8.req_ready_o, 1);
            chk("idle_scan_en", se8, 0);
            chk("idle_rsp_valid", b8.rsp_valid_o, 0);
        end

        preload8(8'h00);
        op8(8'hA5, 0, 8'h00, 0, 0, 8'h00, got);
        chk("first_rsp_zero", got, 8'h00);
        chk("first_chain", c8, 8'hA5 == 8'hA5 ? 8'b1010_0101 : 8'h00);
        op8(8'h3C, 0, 8'h00, 0, 0, 8'h00, got);
        chk("b2b_rsp", got, 8'hA5);
        chk("b2b_chain", c8, 8'b0011_1100);

        op8(8'h00, 1, 8'hFF, 0, 0, 8'h00, got);
        chk("capture_rsp", got, 8'hFF);

        op8(8'h5A, 0, 8'h00, 5, 1, 8'hC3, got);
        op8(8'hC3, 0, 8'h00, 0, 0, 8'h00, got);
        chk("held_req_rsp", got, 8'h5A);

        // Reset in the third shift cycle aborts the pass.
        b8.req_valid_i = 1'b1; b8.req_data_i = 8'h96; b8.req_capture_i = 1'b0;
        @(negedge clk);
        b8.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift_scan_en", se8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_scan_en", se8, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_req_ready", b8.req_ready_o, 1);
        repeat (12) @(negedge clk);
        chk("abort_no_rsp", b8.rsp_valid_o, 0);

        // Single-cell chain.
        fd1 = 1'b0; fen1 = 1'b1;
        @(negedge clk);
        fen1 = 1'b0;
        b1.req_valid_i = 1'b1; b1.req_data_i = 1'b1;
        k1 = 0; sec1 = 0;
        while (!b1.rsp_valid_o && k1 < 20) begin
            @(negedge clk);
            k1++;
            b1.req_valid_i = 1'b0;
            if (se1) sec1++;
        end
        chk("len1_latency", k1, 2);
        chk("len1_scan_en_cycles", sec1, 1);
        chk("len1_rsp", b1.rsp_data_o, 0);
        chk("len1_cell", c1, 1);
        b1.rsp_ready_i = 1'b1;
        @(negedge clk);
        b1.rsp_ready_i = 1'b0;
        chk("len1_idle", b1.req_ready_o, 1);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                int'($urandom_range(0, 3)), 0, 8'h00, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
